// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path: RGB565 colours, pattern mode
// encodings and the 1024x600 active-area constants that the timing
// generator also uses.
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 1024;
  localparam int LCD_V_ACTIVE = 600;

  // RGB565 colours packed as {R[4:0], G[5:0], B[4:0]}
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_GRAD   = 2'd3
  } mode_e;

  // Colour of vertical bar idx, left to right
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = C_WHITE;
      3'd1:    bar_colour = C_YELLOW;
      3'd2:    bar_colour = C_CYAN;
      3'd3:    bar_colour = C_GREEN;
      3'd4:    bar_colour = C_MAGENTA;
      3'd5:    bar_colour = C_RED;
      3'd6:    bar_colour = C_BLUE;
      default: bar_colour = C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_sync_delay.sv
// N-stage register chain for DE/HSYNC/VSYNC, synchronous reset to 0.
module lcd_sync_delay #(
  parameter int N = 2,
  parameter int W = 3
) (
  input  logic         PixelClk,
  input  logic         RST,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  // Shift the sync bundle one stage per clock
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/lcd_pattern_gen.sv
// RGB565 test-pattern source sitting between the LCD timing generator and
// the panel pins. Two-stage pipeline: S1 captures the pattern index, S2
// looks up the colour. Sync/DE ride through a matching 2-stage delay.
// Pattern mode and animation only change at frame start (VSYNC rising).
// Optional build macro LCD_PAT_BORDER_EN adds a 1-pixel white frame border.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE    = LCD_H_ACTIVE,
  parameter int V_ACTIVE    = LCD_V_ACTIVE,
  parameter int BAR_LOG2    = 7,
  parameter int CHK_LOG2    = 5,
  parameter int SCROLL_STEP = 4,
  parameter int FRAME_W     = 8
) (
  input  logic               PixelClk,
  input  logic               RST,
  input  logic [1:0]         Mode,
  input  logic               In_DE,
  input  logic               In_HSYNC,
  input  logic               In_VSYNC,
  input  logic [15:0]        PixelX,
  input  logic [15:0]        LineY,
  output logic               LCD_DE,
  output logic               LCD_HSYNC,
  output logic               LCD_VSYNC,
  output logic [4:0]         LCD_R,
  output logic [5:0]         LCD_G,
  output logic [4:0]         LCD_B,
  output logic [FRAME_W-1:0] FrameCnt
);

  // One full scroll cycle spans all eight bars
  localparam int SCROLL_MOD = 8 << BAR_LOG2;

  logic        vs_prev;
  mode_e       mode_q;
  logic        frame_start;

  logic [31:0] scroll_prod;
  logic [16:0] bar_offset;
  logic [16:0] bar_sum;
  logic [2:0]  bar_idx;

  logic        de_s1;
  mode_e       mode_s1;
  logic [2:0]  bar_idx_s1;
  logic        chk_s1;
  logic [15:0] grad_s1;
  logic [15:0] pix_colour;
  logic [15:0] rgb_q;

  assign frame_start = In_VSYNC & ~vs_prev;

  // Frame bookkeeping: latch requested mode and count frames at VSYNC rise
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      vs_prev  <= 1'b0;
      mode_q   <= MODE_BARS;
      FrameCnt <= '0;
    end else begin
      vs_prev <= In_VSYNC;
      if (frame_start) begin
        mode_q   <= mode_e'(Mode);
        FrameCnt <= FrameCnt + 1'b1;
      end
    end
  end

  // Bar index, with the per-frame scroll offset applied in scroll mode
  assign scroll_prod = 32'(FrameCnt) * 32'(SCROLL_STEP);
  always_comb begin
    bar_offset = 17'd0;
    if (mode_q == MODE_SCROLL) bar_offset = 17'(scroll_prod % 32'(SCROLL_MOD));
  end
  assign bar_sum = {1'b0, PixelX} + bar_offset;
  assign bar_idx = 3'(bar_sum >> BAR_LOG2);

  // S1: capture DE, the active mode and every pattern's index
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      de_s1      <= 1'b0;
      mode_s1    <= MODE_BARS;
      bar_idx_s1 <= '0;
      chk_s1     <= 1'b0;
      grad_s1    <= '0;
    end else begin
      de_s1      <= In_DE;
      mode_s1    <= mode_q;
      bar_idx_s1 <= bar_idx;
      chk_s1     <= PixelX[CHK_LOG2] ^ LineY[CHK_LOG2];
      grad_s1    <= {PixelX[9:5], PixelX[9:4], LineY[9:5]};
    end
  end

`ifdef LCD_PAT_BORDER_EN
  logic border_s1;

  // S1: flag the outermost row/column of the active area
  always_ff @(posedge PixelClk) begin
    if (RST) border_s1 <= 1'b0;
    else     border_s1 <= (PixelX == 16'd0) || (PixelX == 16'(H_ACTIVE - 1)) ||
                          (LineY  == 16'd0) || (LineY  == 16'(V_ACTIVE - 1));
  end
`else
  // Only a few LineY bits feed the patterns when no border is built
  logic unused_line_bits;
  assign unused_line_bits = ^LineY;
`endif

  // S2 colour lookup from the S1 indices
  always_comb begin
    pix_colour = C_BLACK;
    case (mode_s1)
      MODE_BARS, MODE_SCROLL: pix_colour = bar_colour(bar_idx_s1);
      MODE_CHECK:             pix_colour = chk_s1 ? C_WHITE : C_BLACK;
      MODE_GRAD:              pix_colour = grad_s1;
      default:                pix_colour = C_BLACK;
    endcase
`ifdef LCD_PAT_BORDER_EN
    if (border_s1) pix_colour = C_WHITE;
`endif
  end

  // S2: register colour, blanked outside the active area
  always_ff @(posedge PixelClk) begin
    if (RST) rgb_q <= '0;
    else     rgb_q <= de_s1 ? pix_colour : C_BLACK;
  end

  assign LCD_R = rgb_q[15:11];
  assign LCD_G = rgb_q[10:5];
  assign LCD_B = rgb_q[4:0];

  lcd_sync_delay #(.N(2), .W(3)) u_sync_delay (
    .PixelClk (PixelClk),
    .RST      (RST),
    .d        ({In_DE, In_HSYNC, In_VSYNC}),
    .q        ({LCD_DE, LCD_HSYNC, LCD_VSYNC})
  );

endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
Pixel-source stage placed directly downstream of the 1024x600 LCD timing generator and directly upstream of the panel pins. It consumes the generator's pixel/line counters and raw DE/HSYNC/VSYNC. It produces registered RGB565 test patterns together with sync/DE outputs delayed to stay aligned. Pattern mode changes and animation advance only at frame boundaries, so the panel never shows tearing.

Parameters:
H_ACTIVE, 1024, active pixels per line
V_ACTIVE, 600, active lines per frame
BAR_LOG2, 7, log2 of colour-bar width in pixels (128)
CHK_LOG2, 5, log2 of checkerboard square size (32)
SCROLL_STEP, 4, pixels the scrolling bars advance per frame
FRAME_W, 8, frame counter width

Ports:
PixelClk  in  1  pixel clock; the only clock
RST  in  1  synchronous reset, active-high
Mode  in  2  requested pattern: 0 bars, 1 scrolling bars, 2 checkerboard, 3 gradient
In_DE  in  1  data enable from timing generator
In_HSYNC  in  1  hsync from timing generator
In_VSYNC  in  1  vsync from timing generator, active-high
PixelX  in  16  current pixel column
LineY  in  16  current line
LCD_DE  out  1  In_DE delayed 2 cycles
LCD_HSYNC  out  1  In_HSYNC delayed 2 cycles
LCD_VSYNC  out  1  In_VSYNC delayed 2 cycles
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue
FrameCnt  out  FRAME_W  completed-frame counter

Behaviour:
- Interface: one clock, PixelClk. Reset RST is synchronous and active-high.
- Reset values: every output 0, both delay stages 0, the latched mode (mode_q) 0, FrameCnt 0, vs_prev 0.
- Frame start is the cycle where In_VSYNC=1 and vs_prev=0. vs_prev is In_VSYNC registered.
- At frame start: mode_q <= Mode, and FrameCnt <= FrameCnt+1, wrapping from 2^FRAME_W-1 to 0.
- Mode changes at any other time have no effect until the next frame start.
- Pipeline, latency exactly 2 PixelClk cycles from inputs to every output:
  - S1 registers the control inputs and the pattern index.
  - S2 registers the colour lookup and the sync/DE signals.
- Bar index = ((PixelX + offset) >> BAR_LOG2) mod 8, where:
  - offset = 0 in mode 0;
  - offset = (FrameCnt*SCROLL_STEP) mod (8<<BAR_LOG2) in mode 1, computed at the wider width and then truncated.
- Bar colours, index 0..7: white(1F,3F,1F), yellow(1F,3F,00), cyan(00,3F,1F), green(00,3F,00), magenta(1F,00,1F), red(1F,00,00), blue(00,00,1F), black.
- Mode 2: white when PixelX[CHK_LOG2] XOR LineY[CHK_LOG2] = 1, black otherwise.
- Mode 3: R=PixelX[9:5], G=PixelX[9:4], B=LineY[9:5].
- Blanking: RGB is forced to 0 in S2 whenever the S1 copy of In_DE is 0.
- Sync/DE: passed through unmodified except for the 2-cycle delay. No polarity inversion.
- PixelX >= H_ACTIVE or LineY >= V_ACTIVE with In_DE=1: colour is still computed from the counters, with no clamping.
- RST asserted mid-frame: the next edge applies the reset values above. After release, the first frame start latches Mode.

Optional Feature:
LCD_PAT_BORDER_EN
- Defined: a 1-pixel white border (1F,3F,1F) overrides the pattern in S2 when PixelX==0, PixelX==H_ACTIVE-1, LineY==0 or LineY==V_ACTIVE-1. The override requires In_DE. Latency is unchanged.
- Undefined: no border logic is present; the pattern covers the full active area.

Decomposition:
- Package lcd_pkg holds:
  - the RGB565 colour localparams (C_WHITE..C_BLACK as 16-bit {R,G,B});
  - the mode encodings MODE_BARS, MODE_SCROLL, MODE_CHECK, MODE_GRAD;
  - the 1024x600 active-area constants, shared with the timing generator.
- One natural sub-module: lcd_sync_delay, a parameterised N-stage register chain for DE/HSYNC/VSYNC with synchronous reset to 0.

Test Plan:
- Reset: hold RST=1 for 4 cycles with In_DE=1 -> all outputs 0 and FrameCnt=0. Release -> first non-zero RGB appears exactly 2 cycles after the first In_DE=1.
- Mode 0, In_DE=1, LineY=10, PixelX=0,128,256,...,896 -> RGB 2 cycles later = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Mode 1 after 3 frame starts (FrameCnt=3, offset 12), PixelX=116 -> index 1, yellow FFE0. PixelX=115 -> white FFFF.
- Change Mode 0->2 mid-frame -> output stays bars until the next In_VSYNC rising edge. Afterwards (PixelX=32, LineY=0) gives FFFF and (32,32) gives 0000.
- In_DE=0 with PixelX=0 in mode 0 -> RGB=0. HSYNC pulse at cycle t appears on LCD_HSYNC at t+2 with the same width.
- Border: with LCD_PAT_BORDER_EN defined, mode 0, PixelX=1023, LineY=300 -> FFFF (bar 7 is otherwise black). Without the macro -> 0000.
